rr_resource_scheduler: RTL and testbench

//  Round-robin scheduler that shares one datapath resource (e.g. unified-buffer or weight-FIFO port)

---
 rtl/rr_sched_pkg.sv | 22 ++
 rtl/fixed_priority_arbiter.sv | 12 +
 rtl/rr_resource_scheduler.sv | 138 +++++++++++++
 tb/tb_rr_resource_scheduler.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rr_sched_pkg.sv
// rtl/rr_sched_pkg.sv - shared types and helpers for the round-robin resource scheduler
package rr_sched_pkg;

  // Widest request vector the index helper can encode.
  localparam int MAX_PORTS = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Binary index of a one-hot vector; zero input yields 0.
  function automatic int unsigned onehot_to_idx(input logic [MAX_PORTS-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (onehot[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fixed_priority_arbiter.sv
// rtl/fixed_priority_arbiter.sv - combinational lowest-index-wins arbiter
module fixed_priority_arbiter #(
  parameter int NUM_PORTS = 8
) (
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  // Isolate the lowest set bit: x & (-x).
  assign gnt_o = req_i & (~req_i + NUM_PORTS'(1));

endmodule

// File: rtl/rr_resource_scheduler.sv
// rtl/rr_resource_scheduler.sv - round-robin transaction-locking scheduler; RR_SCHED_PREEMPT_EN adds MAX_HOLD preemption
module rr_resource_scheduler
  import rr_sched_pkg::*;
#(
  parameter int NUM_PORTS = 8,
  parameter int MAX_HOLD  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PORTS-1:0]         requests,
  input  logic                         done,
  output logic [NUM_PORTS-1:0]         grants,
  output logic                         grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [NUM_PORTS-1:0] ALL_ONES = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grants_q, grants_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;

  logic [NUM_PORTS-1:0] masked_req;
  logic [NUM_PORTS-1:0] gnt_masked;
  logic [NUM_PORTS-1:0] gnt_raw;
  logic [NUM_PORTS-1:0] winner;
  logic [IDX_W-1:0]     winner_idx;
  logic                 any_req;
  logic                 owner_req;
  logic                 preempt;
  logic                 release_ev;
  logic                 new_grant;

  // Requesters at or above the pointer get first pick; otherwise wrap to the lowest requester.
  assign masked_req = requests & (ALL_ONES << ptr_q);

  fixed_priority_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb_masked (
    .req_i (masked_req),
    .gnt_o (gnt_masked)
  );

  fixed_priority_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb_raw (
    .req_i (requests),
    .gnt_o (gnt_raw)
  );

  assign winner     = (|gnt_masked) ? gnt_masked : gnt_raw;
  assign winner_idx = IDX_W'(onehot_to_idx(MAX_PORTS'(winner)));
  assign any_req    = |requests;
  assign owner_req  = |(requests & grants_q);

`ifdef RR_SCHED_PREEMPT_EN
  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  // Last permitted busy cycle of the current owner forces a release.
  assign preempt = (MAX_HOLD > 0) && (state_q == ARB_BUSY) && (hold_cnt_q == HOLD_LAST);

  // Busy-cycle counter restarts with every new grant and rests at 0 while idle.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (new_grant || state_q == ARB_IDLE || MAX_HOLD == 0) begin
      hold_cnt_d = '0;
    end else begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
  end
`else
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD != 0);
  assign preempt = 1'b0;
`endif

  assign release_ev = done | ~owner_req | preempt;

  // Next-state: arbitrate when idle or on owner release, otherwise hold the grant.
  always_comb begin
    state_d   = state_q;
    grants_d  = grants_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    new_grant = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) new_grant = 1'b1;
      end
      ARB_BUSY: begin
        if (release_ev) begin
          if (any_req) begin
            new_grant = 1'b1;
          end else begin
            state_d  = ARB_IDLE;
            grants_d = '0;
            idx_d    = '0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (new_grant) begin
      state_d  = ARB_BUSY;
      grants_d = winner;
      idx_d    = winner_idx;
      ptr_d    = (winner_idx == LAST_IDX) ? '0 : winner_idx + IDX_W'(1);
    end
  end

  // State, pointer and registered grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      grants_q <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      grants_q <= grants_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
    end
  end

  assign grants      = grants_q;
  assign grant_valid = |grants_q;
  assign grant_idx   = idx_q;

endmodule

// File: tb/tb_rr_resource_scheduler.sv
// tb/tb_rr_resource_scheduler.sv - directed plus random checks of rr_resource_scheduler against a queue-free round-robin model
module tb_rr_resource_scheduler;

  localparam int N  = 4;
  localparam int MH = 4;
`ifdef RR_SCHED_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] requests;
  logic         done;
  logic [N-1:0] grants;
  logic         grant_valid;
  logic [1:0]   grant_idx;

  int n_assert;
  int n_fail;

  int m_owner;
  int m_ptr;
  int m_held;

  rr_resource_scheduler #(.NUM_PORTS(N), .MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .requests    (requests),
    .done        (done),
    .grants      (grants),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
  endtask

  // First requester found scanning upward from the pointer, wrapping around.
  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic d);
    bit rel;
    int w;
    if (m_owner < 0) rel = 1'b1;
    else rel = d || !r[m_owner] || (PREEMPT && MH > 0 && m_held >= MH);
    if (rel) begin
      w = pick(r);
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_held  = 1;
      end else begin
        m_owner = -1;
        m_held  = 0;
      end
    end else begin
      m_held++;
    end
  endtask

  task automatic check_outputs(input logic [N-1:0] r_prev);
    logic [N-1:0] exp_g;
    exp_g = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    chk("grants", 32'(grants), 32'(exp_g));
    chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
    chk("grant_idx", 32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("onehot", 32'($countones(grants) <= 1), 32'd1);
    chk("no_grant_without_req", 32'(grants & ~r_prev), 32'd0);
  endtask

  task automatic step(input logic [N-1:0] r, input logic d);
    requests = r;
    done     = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    check_outputs(r);
  endtask

  initial begin
    logic [N-1:0] r;
    logic         d;
    n_assert = 0;
    n_fail   = 0;
    model_reset();

    // Reset held with all requests asserted
    rst_n    = 1'b0;
    requests = 4'b1111;
    done     = 1'b0;
    #12;
    chk("reset_grants", 32'(grants), 32'd0);
    chk("reset_valid", 32'(grant_valid), 32'd0);
    chk("reset_idx", 32'(grant_idx), 32'd0);
    rst_n = 1'b1;
    step(4'b1111, 1'b0);
    chk("first_grant", 32'(grants), 32'b0001);

    // Back-to-back rotation with done every cycle
    step(4'b1111, 1'b1);
    chk("rot_1", 32'(grants), 32'b0010);
    step(4'b1111, 1'b1);
    chk("rot_2", 32'(grants), 32'b0100);
    step(4'b1111, 1'b1);
    chk("rot_3", 32'(grants), 32'b1000);
    step(4'b1111, 1'b1);
    chk("rot_wrap", 32'(grants), 32'b0001);

    // Two requesters, no done: preemption or indefinite hold
    step(4'b0101, 1'b1);
    for (int i = 0; i < 10; i++) step(4'b0101, 1'b0);

    // Owner drops request with nobody else waiting
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    chk("idle_after_drop", 32'(grant_valid), 32'd0);

    // Asynchronous reset pulse between edges while busy
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grants", 32'(grants), 32'd0);
    chk("async_rst_valid", 32'(grant_valid), 32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(4'b1111, 1'b0);
    chk("resume_ptr0", 32'(grants), 32'b0001);

    // Sole requester re-granted on every done
    step(4'b1000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b1000, 1'b1);
      chk("sole_idx", 32'(grant_idx), 32'd3);
    end

    // Random traffic: requests mostly stable, done occasional
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) r = N'($urandom);
      d = ($urandom_range(0, 3) == 0);
      step(r, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
